// File: rtl/cpu_core_if.sv
// Instruction-fetch bus between cpu_core and its instruction memory.
// The core is the master: it drives PCOUT, ILLEGAL and BUSY.
interface cpu_core_if;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic [31:0] PCOUT;
  logic        ILLEGAL;
  logic        BUSY;

  modport master (
    input  INSTRUCTION,
    input  INSTR_VALID,
    output PCOUT,
    output ILLEGAL,
    output BUSY
  );

  modport slave (
    output INSTRUCTION,
    output INSTR_VALID,
    input  PCOUT,
    input  ILLEGAL,
    input  BUSY
  );
endinterface

// File: rtl/cpu_core.sv
// Two-state (fetch/execute) CPU core: register file, ALU, PC and control.
// Stalls in FETCH until the instruction memory signals a valid word.
module cpu_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REG_COUNT  = 8
) (
  input logic        CLK,
  input logic        RESET,
  cpu_core_if.master bus
);

  localparam int unsigned IdxW = $clog2(REG_COUNT);

  typedef enum logic [0:0] {StFetch, StExec} state_e;

  state_e                state_q, state_d;
  logic [31:0]           ir_q, ir_d;
  logic [31:0]           pc_q, pc_d;
  logic                  illegal_q, illegal_d;
  logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];

  logic [7:0]            opcode;
  logic [IdxW-1:0]       rd, rs1, rs2;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val, wdata;
  logic                  rf_we;
  logic [31:0]           pc_plus4, pc_branch;
  logic                  unused_ir;

  assign opcode  = ir_q[31:24];
  assign rd      = ir_q[16 +: IdxW];
  assign rs1     = ir_q[8 +: IdxW];
  assign rs2     = ir_q[0 +: IdxW];
  assign rs1_val = rf_q[rs1];
  assign rs2_val = rf_q[rs2];

  // Branch offset counts words relative to the following instruction.
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_branch = pc_plus4 + {{22{ir_q[23]}}, ir_q[23:16], 2'b00};

  // Upper register-index bits are ignored when REG_COUNT < 256.
  assign unused_ir = ^ir_q;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    illegal_d = 1'b0;
    rf_we     = 1'b0;
    wdata     = '0;
    unique case (state_q)
      StFetch: begin
        if (bus.INSTR_VALID) begin
          ir_d    = bus.INSTRUCTION;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_plus4;
        case (opcode)
          8'h00: begin
            rf_we = 1'b1;
            wdata = DATA_WIDTH'($signed(ir_q[7:0]));
          end
          8'h01: begin
            rf_we = 1'b1;
            wdata = rs2_val;
          end
          8'h02: begin
            rf_we = 1'b1;
            wdata = rs1_val + rs2_val;
          end
          8'h03: begin
            rf_we = 1'b1;
            wdata = rs1_val - rs2_val;
          end
          8'h04: begin
            rf_we = 1'b1;
            wdata = rs1_val & rs2_val;
          end
          8'h05: begin
            rf_we = 1'b1;
            wdata = rs1_val | rs2_val;
          end
          8'h06: pc_d = pc_branch;
          8'h07: begin
            if (rs1_val == rs2_val) pc_d = pc_branch;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd] <= wdata;
    end
  end

  assign bus.PCOUT   = pc_q;
  assign bus.ILLEGAL = illegal_q;
  assign bus.BUSY    = (state_q == StExec);

endmodule

// File: doc/cpu_core.md
# cpu_core

Parametrised two-state (fetch/execute) successor to the single-cycle lab CPU. Executes the loadi/mov/add/sub/and/or set plus j and beq over a DATA_WIDTH-bit datapath with REG_COUNT registers. Stalls on an instruction-memory valid handshake and flags unknown opcodes. Sits between the instruction memory (driven by PCOUT) and the testbench clock/reset; contains its own register file, ALU and control.

## Interface
- DATA_WIDTH, 8: register and ALU width, 8..32.
- REG_COUNT, 8: number of registers, power of two, 2..256. Register index is the low log2(REG_COUNT) bits of each 8-bit field.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high.
- INSTRUCTION  in  32  instruction word addressed by PCOUT.
- INSTR_VALID  in  1  INSTRUCTION is valid this cycle.
- PCOUT  out  32  registered program counter, byte address.
- ILLEGAL  out  1  one-cycle pulse when an unknown opcode is executed.
- BUSY  out  1  high in EXEC state.

## Operation
- Field map: [31:24] opcode, [23:16] rd or branch offset, [15:8] rs1, [7:0] rs2 or imm8.
- Opcodes:
  - 0x00 loadi: rd = sign-extended imm8, truncated or extended to DATA_WIDTH.
  - 0x01 mov: rd = R[rs2].
  - 0x02 add: rd = R[rs1] + R[rs2].
  - 0x03 sub: rd = R[rs1] + (~R[rs2] + 1).
  - 0x04 and: rd = R[rs1] & R[rs2].
  - 0x05 or: rd = R[rs1] | R[rs2].
  - 0x06 j: PC = PC + 4 + (sext(off8) << 2).
  - 0x07 beq: if R[rs1] == R[rs2], apply the same target as j; else PC + 4.
- Arithmetic is modulo 2^DATA_WIDTH. No carry or overflow is kept.
- Register file: all registers writable, no hard-wired zero. Reads are combinational. There is one write port, written only at the EXEC edge.
- Any other opcode is a NOP. PC advances by 4 and ILLEGAL pulses.
- FSM:
  - FETCH: stay while INSTR_VALID=0. When INSTR_VALID=1, latch INSTRUCTION into IR and go to EXEC.
  - EXEC: at the edge, perform the write-back (data ops only), load the next PC, and go to FETCH.
- PC arithmetic is 32-bit wrap-around. Both 0xFFFFFFFC+4 and negative targets wrap.

## Timing
- Reset (asynchronous assert, immediate effect): PCOUT=0, all registers=0, IR=0, state=FETCH, ILLEGAL=0, BUSY=0.
  - After release, the first IR latch occurs at the first rising edge with INSTR_VALID=1.
- Reset asserted during EXEC aborts the instruction: no register write, PC becomes 0.
- With INSTR_VALID held high, each instruction takes 2 cycles:
  - Edge n latches IR.
  - Edge n+1 writes rd and updates PCOUT.
  - The new PCOUT is visible after edge n+1 and is sampled from edge n+2.
- PCOUT changes only at the EXEC edge. It is stable throughout FETCH, including any stall.
- INSTRUCTION is ignored in EXEC; IR holds the latched value.
- ILLEGAL is registered: high for exactly the cycle following the EXEC edge of the illegal instruction.
- BUSY equals (state==EXEC).
- An instruction whose rs and rd are the same register reads the old value and writes the new one at the same edge. Example: add r1,r1,r1 with r1=3 gives r1=6.

## Test plan
- Reset then stall: RESET pulse, INSTR_VALID=0 for 5 cycles -> PCOUT=0 throughout, BUSY=0, no register change.
- loadi/add/sub wrap (DATA_WIDTH=8): loadi r1,0x05; loadi r2,0x07; sub r3,r1,r2; add r4,r2,r2 -> r3=0xFE, r4=0x0E, PCOUT=16 after the fourth EXEC edge, 8 cycles total.
- Branches: with r1=r2=9, beq off=+2 at PC=8 -> PCOUT=20. With r1≠r2 -> PCOUT=12. j off=0xFF at PC=12 -> PCOUT=12 (self-loop).
- Handshake: INSTR_VALID toggled 1,0,0,1 across instructions -> each instruction completes exactly 1 cycle after its valid edge, and results match the no-stall run.
- Reset mid-EXEC: assert RESET asynchronously between the IR latch and the EXEC edge of loadi r5,0x33 -> r5=0, PCOUT=0 immediately.
- Illegal plus parametrisation: opcode 0x0C -> ILLEGAL high for 1 cycle, PC+4, no register write. Rerun the loadi/add sequence with DATA_WIDTH=16, REG_COUNT=16: loadi r15,0x80 -> r15=0xFF80.
